// File: rtl/tdm_demux_pkg.sv
// Shared types and sizing helpers for the TDM demultiplexer.
package tdm_demux_pkg;

  typedef enum logic {HUNT, LOCK} state_t;

  localparam int ERRCNT_W = 8;

  function automatic int slot_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/tdm_slot_counter.sv
// Modulo-NUM_CH slot counter with clear, load-to-1 and advance controls.
module tdm_slot_counter
  import tdm_demux_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int SW     = slot_w(NUM_CH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          load,
  input  logic          clear,
  output logic [SW-1:0] count,
  output logic          wrap
);

  localparam logic [SW-1:0] LAST = SW'(NUM_CH - 1);

  // Clear beats load beats advance; the top never asserts more than one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (load) begin
      count <= SW'(1);
    end else if (en) begin
      count <= (count == LAST) ? '0 : count + 1'b1;
    end
  end

  assign wrap = en && (count == LAST);

endmodule

// File: rtl/tdm_demux.sv
// TDM demultiplexer with SOF-based frame lock; TDM_DEMUX_ERRCNT_EN adds a
// saturating sync-error counter on port err_count.
module tdm_demux
  import tdm_demux_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int NUM_CH = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    in_valid,
  input  logic [WIDTH-1:0]        in_data,
  input  logic                    in_sof,
  output logic [NUM_CH*WIDTH-1:0] out_data,
  output logic [NUM_CH-1:0]       out_valid,
  output logic                    frame_done,
  output logic                    locked,
  output logic                    sync_err
`ifdef TDM_DEMUX_ERRCNT_EN
  ,
  output logic [ERRCNT_W-1:0]     err_count
`endif
);

  localparam int SW = slot_w(NUM_CH);

  state_t          state;
  logic [SW-1:0]   slot;
  logic            accept;
  logic            cnt_adv;
  logic            cnt_load;
  logic            cnt_clear;
  logic            cnt_wrap;
  logic            err_hit;
  logic [NUM_CH-1:0] lane_we;

  assign accept    = en && in_valid;
  assign cnt_load  = accept && in_sof;
  assign cnt_adv   = accept && !in_sof && (state == LOCK) && (slot != '0);
  assign cnt_clear = accept && !in_sof && (state == LOCK) && (slot == '0);
  assign err_hit   = accept && (state == LOCK) &&
                     ((in_sof && (slot != '0)) || (!in_sof && (slot == '0)));

  tdm_slot_counter #(
    .NUM_CH (NUM_CH),
    .SW     (SW)
  ) u_slot_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (cnt_adv),
    .load  (cnt_load),
    .clear (cnt_clear),
    .count (slot),
    .wrap  (cnt_wrap)
  );

  always_comb begin
    lane_we = '0;
    if (cnt_load) begin
      lane_we[0] = 1'b1;
    end else if (cnt_adv) begin
      lane_we[slot] = 1'b1;
    end
  end

  // Pulses last one cycle; lanes only change when their write enable fires.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= HUNT;
      locked     <= 1'b0;
      sync_err   <= 1'b0;
      frame_done <= 1'b0;
      out_valid  <= '0;
      out_data   <= '0;
    end else begin
      out_valid  <= lane_we;
      frame_done <= cnt_wrap;
      sync_err   <= err_hit;
      for (int k = 0; k < NUM_CH; k++) begin
        if (lane_we[k]) begin
          out_data[k*WIDTH +: WIDTH] <= in_data;
        end
      end
      case (state)
        HUNT: begin
          if (cnt_load) begin
            state  <= LOCK;
            locked <= 1'b1;
          end
        end
        LOCK: begin
          if (cnt_clear) begin
            state  <= HUNT;
            locked <= 1'b0;
          end
        end
        default: begin
          state  <= HUNT;
          locked <= 1'b0;
        end
      endcase
    end
  end

`ifdef TDM_DEMUX_ERRCNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count <= '0;
    end else if (err_hit && (err_count != '1)) begin
      err_count <= err_count + 1'b1;
    end
  end
`endif

endmodule

// File: doc/tdm_demux.md
# tdm_demux

Time-division demultiplexer: receives a single WIDTH-bit stream carrying NUM_CH interleaved channel slots, framed by a start-of-frame marker, and routes each slot into its own registered output lane. It is the receive end of the multiplexed datapath: it rebuilds the per-channel words that a select-driven multiplexer interleaved onto one bus. It tracks frame alignment with a small lock state machine and flags misalignment.

## Interface
Parameters:
- WIDTH, 4, bits per slot word.
- NUM_CH, 2, slots per frame; power of two, 2..8.

Ports:
- clk  input  1  clock; all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  enable; when low, input beats are ignored and all state is held.
- in_valid  input  1  input beat present this cycle.
- in_data  input  WIDTH  slot word.
- in_sof  input  1  qualifies the beat as slot 0; meaningful only with in_valid.
- out_data  output  NUM_CH*WIDTH  lane k occupies bits [k*WIDTH +: WIDTH].
- out_valid  output  NUM_CH  one-cycle pulse per lane when that lane updates.
- frame_done  output  1  one-cycle pulse when slot NUM_CH-1 is written.
- locked  output  1  high in LOCK state.
- sync_err  output  1  one-cycle pulse on an alignment error.

Reset is asynchronous and active-low (rst_n), with a single clock (clk).

## Operation
- An accepted beat requires en=1 and in_valid=1. Nothing else changes state.
- State HUNT (reset state):
  - An accepted beat with in_sof=1 writes lane 0, sets slot counter to 1, and moves to LOCK.
  - An accepted beat with in_sof=0 is dropped. No error is raised.
- State LOCK, with an accepted beat and slot counter value s:
  - in_sof=0 and s!=0: write lane s, then s <= s+1 modulo NUM_CH. If s==NUM_CH-1, pulse frame_done and wrap to 0.
  - in_sof=1 and s==0: normal frame start. Write lane 0, s <= 1.
  - in_sof=1 and s!=0: early SOF. Pulse sync_err, write lane 0, s <= 1, stay in LOCK (realign).
  - in_sof=0 and s==0: missing SOF. Pulse sync_err, drop the beat, go to HUNT.
- Lanes not written keep their value. No partial-frame clearing.
- Reset values: out_data all 0, out_valid 0, frame_done 0, locked 0, sync_err 0, slot counter 0, state HUNT.

## Timing
- Latency is 1 cycle. A beat accepted at edge n shows on out_data/out_valid at edge n+1.
- frame_done is coincident with out_valid[NUM_CH-1].
- sync_err is registered, with the same 1-cycle latency as the beat that caused it.
- locked rises in the cycle after the first SOF beat is accepted. It falls in the cycle after a missing-SOF error.
- Back-to-back beats every cycle are supported. There is no backpressure; every accepted beat is consumed.
- If en goes low mid-frame, the slot counter freezes. The frame resumes at the same slot when en returns high.
- Asserting rst_n low mid-frame clears everything immediately, asynchronously.

## Configuration
- TDM_DEMUX_ERRCNT_EN defined:
  - Adds output port err_count (8 bits).
  - The counter increments on every sync_err pulse and saturates at 255.
  - It clears only on reset.
- TDM_DEMUX_ERRCNT_EN undefined: the port and counter are absent. All other behaviour is identical.

## Structure
- Package tdm_demux_pkg holds:
  - the state enum (HUNT, LOCK);
  - the slot-counter width function, clog2(NUM_CH);
  - ERRCNT_W = 8.
- Sub-module tdm_slot_counter: modulo-NUM_CH counter with en, load-to-1 and clear inputs, and a wrap output. Lane write-enable decode and the FSM stay in the top module.

## Test plan
- Reset, then with NUM_CH=2, beats A(sof), B → locked=1, lane0=A and lane1=B one cycle after each beat, frame_done on the B cycle, sync_err never.
- 3 continuous frames at 1 beat/cycle (NUM_CH=4) → each lane pulses out_valid once per frame, frame_done every 4th cycle.
- In LOCK, SOF on slot 2 (NUM_CH=4) → sync_err pulse, lane0 updated, next beat written to lane1, locked stays 1.
- After a full frame, a non-SOF beat at slot 0 → sync_err, beat dropped, locked falls. A following non-SOF beat is ignored. A following SOF beat relocks.
- en low for 3 cycles mid-frame with in_valid=1 → no outputs change. Resuming writes the next expected slot.
- With TDM_DEMUX_ERRCNT_EN: force 300 errors → err_count saturates at 255. Assert rst_n low mid-frame → all outputs 0 and err_count 0.
